// File: rtl/pedido_ctrl.sv
// Order front end for the beverage machine: collects coin credit, validates a
// drink request, drives sel to the preparation controller and returns change.
module pedido_ctrl #(
  parameter int unsigned PRICE_CAFE  = 4,
  parameter int unsigned PRICE_LECHE = 5,
  parameter int unsigned PRICE_CHOC  = 6,
  parameter int unsigned PRICE_CAPU  = 7,
  parameter int unsigned CREDIT_MAX  = 15,
  parameter int unsigned SEL_HOLD    = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       coin_i,
  input  logic [3:0] btn_i,
  input  logic       cancel_i,
  input  logic       finish_i,
  output logic [2:0] sel_o,
  output logic       busy_o,
  output logic [7:0] credit_o,
  output logic       change_valid_o,
  output logic [7:0] change_o,
  output logic       error_o
);

  localparam int HW = (SEL_HOLD > 1) ? $clog2(SEL_HOLD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]    CREDIT_MAX8 = 8'(CREDIT_MAX);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(SEL_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_FIN,
    CHANGE,
    ERROR
  } state_t;

  state_t        state_q;
  logic [2:0]    sel_q;
  logic          busy_q;
  logic [7:0]    credit_q;
  logic          changeValid_q;
  logic [7:0]    change_q;
  logic          error_q;
  logic [HW-1:0] holdCnt_q;
  logic [TW-1:0] toCnt_q;

  logic [7:0]    creditCoin_d;
  logic          reqValid_d;
  logic [2:0]    reqCode_d;
  logic [7:0]    reqPrice_d;
  logic          reqAccept_d;
  logic          cancelAccept_d;

  // Credit as it would stand after this cycle's coin; both refund and purchase
  // decisions are taken against this value so a coincident coin is not lost.
  always_comb begin
    creditCoin_d = credit_q;
    if (coin_i && (credit_q < CREDIT_MAX8)) begin
      creditCoin_d = credit_q + 8'd1;
    end

    reqValid_d = 1'b0;
    reqCode_d  = 3'b000;
    reqPrice_d = 8'd0;
    unique case (btn_i)
      4'b0001: begin reqValid_d = 1'b1; reqCode_d = 3'b001; reqPrice_d = 8'(PRICE_CAFE);  end
      4'b0010: begin reqValid_d = 1'b1; reqCode_d = 3'b010; reqPrice_d = 8'(PRICE_LECHE); end
      4'b0100: begin reqValid_d = 1'b1; reqCode_d = 3'b011; reqPrice_d = 8'(PRICE_CHOC);  end
      4'b1000: begin reqValid_d = 1'b1; reqCode_d = 3'b100; reqPrice_d = 8'(PRICE_CAPU);  end
      default: begin reqValid_d = 1'b0; reqCode_d = 3'b000; reqPrice_d = 8'd0;            end
    endcase

    cancelAccept_d = cancel_i && (creditCoin_d != 8'd0);
    reqAccept_d    = reqValid_d && (creditCoin_d >= reqPrice_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      sel_q         <= 3'b000;
      busy_q        <= 1'b0;
      credit_q      <= 8'd0;
      changeValid_q <= 1'b0;
      change_q      <= 8'd0;
      error_q       <= 1'b0;
      holdCnt_q     <= '0;
      toCnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cancelAccept_d) begin
            state_q       <= CHANGE;
            busy_q        <= 1'b1;
            changeValid_q <= 1'b1;
            change_q      <= creditCoin_d;
            credit_q      <= 8'd0;
          end else if (reqAccept_d) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            sel_q     <= reqCode_d;
            credit_q  <= creditCoin_d - reqPrice_d;
            holdCnt_q <= '0;
          end else begin
            credit_q <= creditCoin_d;
          end
        end

        ISSUE: begin
          if (holdCnt_q == HOLD_LAST) begin
            state_q <= WAIT_FIN;
            sel_q   <= 3'b000;
            toCnt_q <= '0;
          end else begin
            holdCnt_q <= holdCnt_q + 1'b1;
          end
        end

        WAIT_FIN: begin
          if (finish_i) begin
            state_q       <= CHANGE;
            changeValid_q <= 1'b1;
            change_q      <= credit_q;
            credit_q      <= 8'd0;
          end else if (toCnt_q == TO_LAST) begin
            state_q <= ERROR;
            error_q <= 1'b1;
          end else begin
            toCnt_q <= toCnt_q + 1'b1;
          end
        end

        CHANGE: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          changeValid_q <= 1'b0;
          change_q      <= 8'd0;
        end

        // Locked until reset; credit is kept so it can be refunded by hand.
        ERROR: begin
          state_q <= ERROR;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sel_q   <= 3'b000;
        end
      endcase
    end
  end

  assign sel_o          = sel_q;
  assign busy_o         = busy_q;
  assign credit_o       = credit_q;
  assign change_valid_o = changeValid_q;
  assign change_o       = change_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_pedido_ctrl.sv
// Self-checking bench for pedido_ctrl: cycle-by-cycle vector table plus
// hand-written sequences for saturation, timeout and reset mid-order.
module tb_pedido_ctrl;

  logic       clk;
  logic       rst;
  logic       coin;
  logic [3:0] btn;
  logic       cancel;
  logic       finish;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] credit;
  logic       changeValid;
  logic [7:0] change;
  logic       error;

  int checks;
  int failures;

  pedido_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .coin_i         (coin),
    .btn_i          (btn),
    .cancel_i       (cancel),
    .finish_i       (finish),
    .sel_o          (sel),
    .busy_o         (busy),
    .credit_o       (credit),
    .change_valid_o (changeValid),
    .change_o       (change),
    .error_o        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       coin;
    logic [3:0] btn;
    logic       cancel;
    logic       finish;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] credit;
    logic       cv;
    logic [7:0] change;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic r, input logic c, input logic [3:0] b,
                        input logic ca, input logic f, input logic [2:0] s,
                        input logic bz, input logic [7:0] cr, input logic v,
                        input logic [7:0] ch, input logic e);
    vec_t t;
    t.rst = r; t.coin = c; t.btn = b; t.cancel = ca; t.finish = f;
    t.sel = s; t.busy = bz; t.credit = cr; t.cv = v; t.change = ch; t.err = e;
    vecs.push_back(t);
  endtask

  // Idle-state coin pulses, credit rising from start+1 to start+n.
  task automatic addCoins(input int n, input int start);
    for (int k = 1; k <= n; k++) begin
      addRow(0, 1, 4'b0000, 0, 0, 3'b000, 0, 8'(start + k), 0, 8'd0, 0);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic [3:0] b,
                               input logic ca, input logic f);
    rst = r; coin = c; btn = b; cancel = ca; finish = f;
    @(posedge clk);
    #1;
    rst = 1'b0; coin = 1'b0; btn = 4'b0000; cancel = 1'b0; finish = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] s, input logic bz,
                             input logic [7:0] cr, input logic v, input logic [7:0] ch,
                             input logic e);
    checks++;
    if ({sel, busy, credit, changeValid, change, error} !== {s, bz, cr, v, ch, e}) begin
      failures++;
      $display("[TB] FAIL %s: got sel=%b busy=%b credit=%0d cv=%b change=%0d err=%b, expected sel=%b busy=%b credit=%0d cv=%b change=%0d err=%b",
               name, sel, busy, credit, changeValid, change, error, s, bz, cr, v, ch, e);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; coin = 1'b0; btn = 4'b0000; cancel = 1'b0; finish = 1'b0;

    // Reset and idle
    addRow(1, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    addRow(1, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Black coffee with one unit of change; early finish during ISSUE ignored
    addCoins(5, 0);
    addRow(0, 0, 4'b0001, 0, 0, 3'b001, 1, 8'd1, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b001, 1, 8'd1, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 1, 3'b000, 1, 8'd1, 0, 8'd0, 0);
    addRow(0, 1, 4'b0000, 0, 0, 3'b000, 1, 8'd1, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 1, 3'b000, 1, 8'd0, 1, 8'd1, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Insufficient credit and multi-bit request both ignored
    addCoins(3, 0);
    addRow(0, 0, 4'b0001, 0, 0, 3'b000, 0, 8'd3, 0, 8'd0, 0);
    addCoins(4, 3);
    addRow(0, 0, 4'b0011, 0, 0, 3'b000, 0, 8'd7, 0, 8'd0, 0);
    // Cancel refunds all credit
    addRow(0, 0, 4'b0000, 1, 0, 3'b000, 1, 8'd0, 1, 8'd7, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Coin together with capuccino request: 6+1 covers price 7
    addCoins(6, 0);
    addRow(0, 1, 4'b1000, 0, 0, 3'b100, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b100, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 1, 3'b000, 1, 8'd0, 1, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Cancel with zero credit ignored; coin plus cancel refunds the new coin
    addRow(0, 0, 4'b0000, 1, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    addRow(0, 1, 4'b0000, 1, 0, 3'b000, 1, 8'd0, 1, 8'd1, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Cancel beats a simultaneous valid request
    addCoins(5, 0);
    addRow(0, 0, 4'b0001, 1, 0, 3'b000, 1, 8'd0, 1, 8'd5, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Chocolate order
    addCoins(6, 0);
    addRow(0, 0, 4'b0100, 0, 0, 3'b011, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b011, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 1, 3'b000, 1, 8'd0, 1, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    // Leche order aborted by reset while waiting for finish
    addCoins(5, 0);
    addRow(0, 0, 4'b0010, 0, 0, 3'b010, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b010, 1, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 1, 8'd0, 0, 8'd0, 0);
    addRow(1, 0, 4'b0000, 0, 1, 3'b000, 0, 8'd0, 0, 8'd0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 3'b000, 0, 8'd0, 0, 8'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].coin, vecs[i].btn, vecs[i].cancel, vecs[i].finish);
      checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].busy, vecs[i].credit,
                  vecs[i].cv, vecs[i].change, vecs[i].err);
    end

    // Saturation: 20 coins leave credit at 15, cancel refunds 15
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 4'b0000, 0, 0);
    checkOutput("saturate", 3'b000, 0, 8'd15, 0, 8'd0, 0);
    applyStimulus(0, 0, 4'b0000, 1, 0);
    checkOutput("cancel15", 3'b000, 1, 8'd0, 1, 8'd15, 0);
    applyStimulus(0, 0, 4'b0000, 0, 0);
    checkOutput("cancel15_idle", 3'b000, 0, 8'd0, 0, 8'd0, 0);

    // Timeout: 6 coins, cafe leaves credit 2, finish never arrives
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 4'b0000, 0, 0);
    applyStimulus(0, 0, 4'b0001, 0, 0);
    checkOutput("to_accept", 3'b001, 1, 8'd2, 0, 8'd0, 0);
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, 4'b0000, 0, 0);
    checkOutput("to_before", 3'b000, 1, 8'd2, 0, 8'd0, 0);
    applyStimulus(0, 0, 4'b0000, 0, 0);
    checkOutput("to_error", 3'b000, 1, 8'd2, 0, 8'd0, 1);
    applyStimulus(0, 1, 4'b0000, 0, 0);
    applyStimulus(0, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 4'b0001, 0, 0);
    applyStimulus(0, 0, 4'b0000, 0, 1);
    checkOutput("error_locked", 3'b000, 1, 8'd2, 0, 8'd0, 1);

    // Reset clears error; reset during ISSUE aborts the order
    applyStimulus(1, 0, 4'b0000, 0, 0);
    checkOutput("rst_clears_err", 3'b000, 0, 8'd0, 0, 8'd0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 4'b0000, 0, 0);
    applyStimulus(0, 0, 4'b0001, 0, 0);
    checkOutput("issue2", 3'b001, 1, 8'd1, 0, 8'd0, 0);
    applyStimulus(1, 1, 4'b0000, 0, 0);
    checkOutput("rst_in_issue", 3'b000, 0, 8'd0, 0, 8'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pedido_ctrl.md
Name: pedido_ctrl

Overview:
User-side order front end for the beverage machine. It accumulates coin credit, accepts a drink request and checks that credit covers the price. It then drives the 3-bit sel code into the preparation controller, waits for that controller's finish pulse, and returns change. It is the initiator end of the sel/finish interface consumed by the preparation controller.

Parameters:
PRICE_CAFE, 4, price of black coffee in credit units
PRICE_LECHE, 5, price of coffee with milk
PRICE_CHOC, 6, price of chocolate
PRICE_CAPU, 7, price of cappuccino
CREDIT_MAX, 15, credit saturation value (fits 8 bits)
SEL_HOLD, 2, cycles sel is held non-zero per order (>=1)
TIMEOUT, 255, max cycles waiting for finish after sel release (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
coin  in  1  one-cycle pulse, adds 1 credit unit
btn  in  4  drink request; bit0 cafe, bit1 leche, bit2 choc, bit3 capu; sampled only in IDLE
cancel  in  1  one-cycle pulse, refund credit (IDLE only)
finish  in  1  preparation done, from preparation controller
sel  out  3  drink code to preparation controller; 000 none, 001 cafe, 010 leche, 011 choc, 100 capu
busy  out  1  high in every state except IDLE
credit  out  8  current credit
change_valid  out  1  one-cycle pulse qualifying change
change  out  8  amount returned; valid only with change_valid
error  out  1  sticky timeout flag, cleared by rst only

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, sel=000, busy=0, credit=0, change=0, change_valid=0, error=0, counters=0. Reset wins over all inputs and aborts any order mid-operation; sel returns to 000 the next cycle.
- States: IDLE, ISSUE, WAIT_FIN, CHANGE, ERROR. All outputs are registered.
- IDLE:
  - coin=1 -> credit+1, saturating at CREDIT_MAX (extra coins are lost).
  - cancel=1 and credit>0 -> go to CHANGE with change=credit, credit=0.
  - btn with exactly one bit set and credit>=price -> ISSUE; latch code; credit-=price; hold counter=0.
  - btn with zero or more than one bit set, or credit<price -> ignored; stay IDLE.
  - Priority when events coincide: cancel > btn > coin. A coin in the same cycle as an accepted btn or cancel is added to credit before the price is subtracted or the refund is taken; the saturation rule still applies.
- ISSUE: sel=latched code for exactly SEL_HOLD cycles, then sel=000 and go to WAIT_FIN with timeout counter=0. coin and btn are ignored while busy.
- WAIT_FIN: sel=000.
  - finish=1 -> CHANGE.
  - Otherwise the counter increments; when it reaches TIMEOUT -> ERROR.
  - finish asserted during ISSUE is ignored. Only finish seen in WAIT_FIN counts.
- CHANGE: one cycle. change_valid=1, change=remaining credit (or the cancel amount); credit=0; then IDLE. If the amount is 0, change_valid is still pulsed with change=0.
- ERROR: error=1, busy=1, sel=000; remaining credit is retained; all inputs are ignored until rst.
- Latency: accepted btn edge -> sel non-zero on the next cycle. finish seen in WAIT_FIN -> change_valid on the next cycle -> IDLE (busy=0) one cycle later.
- Arithmetic: credit is unsigned 8-bit; subtraction cannot underflow because acceptance is gated by credit>=price.

Test Plan:
- Reset then idle: rst 2 cycles, no inputs -> sel=000, busy=0, credit=0, error=0 throughout.
- Black coffee with change: 5 coin pulses, btn=0001 -> credit=1, sel=001 for 2 cycles then 000. finish pulse -> change_valid=1 with change=1 next cycle, then busy=0.
- Insufficient and invalid requests: 3 coins; btn=0001 -> ignored. btn=0011 with 7 coins -> ignored. credit unchanged, sel=000.
- Saturation and cancel: 20 coins -> credit=15. cancel -> change_valid with change=15, credit=0.
- Simultaneous coin and btn: credit=6, coin=1 together with btn=1000 -> accepted (7>=7), credit=0, sel=100.
- Timeout and reset mid-order: order accepted, finish never arrives -> error=1 after SEL_HOLD+TIMEOUT cycles, sel=000. rst during ISSUE on a second run -> sel=000 and credit=0 next cycle.
